// File: rtl/ysyx_25060170_mc_core_pkg.sv
// Shared types and constants for the multi-cycle core: FSM state encoding,
// default reset vector and the ABI index of a0 (used for the halt code).
package ysyx_25060170_core_pkg;

  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    EXEC,
    HALT,
    TRAP
  } core_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int          A0_IDX           = 10;
  localparam int          TIMEOUT_W        = 8;

  // A next PC is only legal when it is word aligned.
  function automatic logic misaligned4(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_25060170_mc_core_if.sv
// Instruction fetch bus: request channel (valid/ready + address) and a
// response channel (valid + data + error). The core is the master.
interface ysyx_25060170_mc_core_if #(
  parameter int XLEN = 32
) ();
  logic            ibus_req_valid;
  logic            ibus_req_ready;
  logic [XLEN-1:0] ibus_addr;
  logic            ibus_rsp_valid;
  logic [31:0]     ibus_rsp_data;
  logic            ibus_rsp_err;

  modport master (
    output ibus_req_valid, ibus_addr,
    input  ibus_req_ready, ibus_rsp_valid, ibus_rsp_data, ibus_rsp_err
  );

  modport slave (
    input  ibus_req_valid, ibus_addr,
    output ibus_req_ready, ibus_rsp_valid, ibus_rsp_data, ibus_rsp_err
  );
endinterface

// File: rtl/ysyx_25060170_mc_core_gpr.sv
// General purpose register file: NR_REGS x XLEN, two combinational read
// ports, one write port. x0 and indices >= NR_REGS read as zero and ignore
// writes. Reads return the pre-write value (no bypass). a0_o is a direct
// tap of x10 used to capture the halt code.
module ysyx_25060170_gpr_n
  import ysyx_25060170_core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NR_REGS = 32,
  parameter int RW      = $clog2(NR_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RW-1:0]   rs1_addr_i,
  input  logic [RW-1:0]   rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            we_i,
  input  logic [RW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] a0_o
);

  // x0 has no storage; entries 1..NR_REGS-1 only.
  logic [XLEN-1:0] regs_q [1:NR_REGS-1];

  logic wr_ok;
  assign wr_ok = we_i && (waddr_i != '0) && (32'(waddr_i) < 32'(NR_REGS));

  // Clear on reset, otherwise a single write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i < NR_REGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read port 1: zero for x0 and out-of-range indices.
  always_comb begin
    rs1_data_o = '0;
    if (rs1_addr_i != '0 && 32'(rs1_addr_i) < 32'(NR_REGS)) rs1_data_o = regs_q[rs1_addr_i];
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rs2_data_o = '0;
    if (rs2_addr_i != '0 && 32'(rs2_addr_i) < 32'(NR_REGS)) rs2_data_o = regs_q[rs2_addr_i];
  end

  generate
    if (NR_REGS > A0_IDX) begin : g_a0
      assign a0_o = regs_q[A0_IDX];
    end else begin : g_no_a0
      assign a0_o = '0;
    end
  endgenerate

endmodule

// File: rtl/ysyx_25060170_mc_core.sv
// Multi-cycle core control: PC, instruction register, GPR file, fetch-bus
// handshake and the FETCH_REQ -> FETCH_WAIT -> EXEC FSM. Decode/ALU live
// outside and are driven through the ex_* ports during EXEC.
// Optional difftest commit outputs: define YSYX_25060170_MC_DIFFTEST_EN.
module ysyx_25060170_mc_core
  import ysyx_25060170_core_pkg::*;
#(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] RESET_PC      = XLEN'(RESET_PC_DEFAULT),
  parameter int              NR_REGS       = 32,
  parameter int              FETCH_TIMEOUT = 255,
  localparam int             RW            = $clog2(NR_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  ysyx_25060170_mc_core_if.master      ibus,
  output logic                         ex_valid,
  output logic [XLEN-1:0]              ex_pc,
  output logic [31:0]                  ex_inst,
  input  logic [RW-1:0]                ex_rs1_addr,
  input  logic [RW-1:0]                ex_rs2_addr,
  output logic [XLEN-1:0]              rs1_data,
  output logic [XLEN-1:0]              rs2_data,
  input  logic                         ex_rd_we,
  input  logic [RW-1:0]                ex_rd_addr,
  input  logic [XLEN-1:0]              ex_rd_wdata,
  input  logic [XLEN-1:0]              ex_next_pc,
  input  logic                         ex_halt,
  output logic                         halted,
  output logic [XLEN-1:0]              halt_code,
  output logic                         trap,
  output logic [63:0]                  commit_cnt
`ifdef YSYX_25060170_MC_DIFFTEST_EN
  ,
  output logic                         commit_valid,
  output logic [XLEN-1:0]              commit_pc,
  output logic [31:0]                  commit_inst,
  output logic [XLEN-1:0]              commit_next_pc
`endif
);

  core_state_e           state_q;
  logic [XLEN-1:0]       pc_q;
  logic [31:0]           ir_q;
  logic                  req_valid_q;
  logic                  ex_valid_q;
  logic                  halted_q;
  logic                  trap_q;
  logic [XLEN-1:0]       halt_code_q;
  logic [63:0]           commit_cnt_q;
  logic [TIMEOUT_W-1:0]  wait_cnt_q;

  logic                  in_exec;
  logic                  npc_bad;
  logic                  exec_retire;
  logic                  gpr_we;
  logic [XLEN-1:0]       a0_val;
  logic [XLEN-1:0]       a0_after;

  assign in_exec     = (state_q == EXEC);
  assign npc_bad     = misaligned4(ex_next_pc[1:0]);
  // An EXEC retires unless it would trap on a misaligned target; ebreak
  // retires regardless of next_pc.
  assign exec_retire = in_exec && (ex_halt || !npc_bad);
  assign gpr_we      = exec_retire && ex_rd_we;
  // Halt code sees this cycle's write to a0 (write-through).
  assign a0_after    = (gpr_we && ex_rd_addr == RW'(A0_IDX)) ? ex_rd_wdata : a0_val;

  ysyx_25060170_gpr_n #(
    .XLEN    (XLEN),
    .NR_REGS (NR_REGS),
    .RW      (RW)
  ) u_gpr (
    .clk        (clk),
    .rst        (rst),
    .rs1_addr_i (ex_rs1_addr),
    .rs2_addr_i (ex_rs2_addr),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .we_i       (gpr_we),
    .waddr_i    (ex_rd_addr),
    .wdata_i    (ex_rd_wdata),
    .a0_o       (a0_val)
  );

  // Core FSM with PC, IR, status flags and counters; outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= FETCH_REQ;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      req_valid_q  <= 1'b1;
      ex_valid_q   <= 1'b0;
      halted_q     <= 1'b0;
      trap_q       <= 1'b0;
      halt_code_q  <= '0;
      commit_cnt_q <= '0;
      wait_cnt_q   <= '0;
    end else begin
      case (state_q)
        FETCH_REQ: begin
          if (ibus.ibus_req_ready) begin
            state_q     <= FETCH_WAIT;
            req_valid_q <= 1'b0;
            wait_cnt_q  <= '0;
          end
        end
        FETCH_WAIT: begin
          if (ibus.ibus_rsp_valid) begin
            if (ibus.ibus_rsp_err) begin
              state_q <= TRAP;
              trap_q  <= 1'b1;
            end else begin
              ir_q       <= ibus.ibus_rsp_data;
              state_q    <= EXEC;
              ex_valid_q <= 1'b1;
            end
          end else if (wait_cnt_q == TIMEOUT_W'(FETCH_TIMEOUT)) begin
            state_q <= TRAP;
            trap_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        EXEC: begin
          ex_valid_q <= 1'b0;
          if (ex_halt) begin
            commit_cnt_q <= commit_cnt_q + 64'd1;
            state_q      <= HALT;
            halted_q     <= 1'b1;
            halt_code_q  <= a0_after;
          end else if (npc_bad) begin
            state_q <= TRAP;
            trap_q  <= 1'b1;
          end else begin
            commit_cnt_q <= commit_cnt_q + 64'd1;
            pc_q         <= ex_next_pc;
            state_q      <= FETCH_REQ;
            req_valid_q  <= 1'b1;
          end
        end
        HALT: state_q <= HALT;
        TRAP: state_q <= TRAP;
        default: begin
          state_q     <= TRAP;
          trap_q      <= 1'b1;
          req_valid_q <= 1'b0;
          ex_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ibus.ibus_req_valid = req_valid_q;
  assign ibus.ibus_addr      = pc_q;
  assign ex_valid            = ex_valid_q;
  assign ex_pc               = pc_q;
  assign ex_inst             = ir_q;
  assign halted              = halted_q;
  assign halt_code           = halt_code_q;
  assign trap                = trap_q;
  assign commit_cnt          = commit_cnt_q;

`ifdef YSYX_25060170_MC_DIFFTEST_EN
  logic            commit_valid_q;
  logic [XLEN-1:0] commit_pc_q;
  logic [31:0]     commit_inst_q;
  logic [XLEN-1:0] commit_next_pc_q;

  // Capture each retiring instruction for the difftest harness.
  always_ff @(posedge clk) begin
    if (!rst) begin
      commit_valid_q   <= 1'b0;
      commit_pc_q      <= '0;
      commit_inst_q    <= '0;
      commit_next_pc_q <= '0;
    end else begin
      commit_valid_q <= exec_retire;
      if (exec_retire) begin
        commit_pc_q      <= pc_q;
        commit_inst_q    <= ir_q;
        commit_next_pc_q <= ex_next_pc;
      end
    end
  end

  assign commit_valid   = commit_valid_q;
  assign commit_pc      = commit_pc_q;
  assign commit_inst    = commit_inst_q;
  assign commit_next_pc = commit_next_pc_q;
`endif

endmodule
